lsu_stbuf_queue: RTL

//  Committed-store buffer feeding the DCCM/PIC port arbiter (lsu_dccm_ctl). Holds up to DEPTH

---
 rtl/lsu_stbuf_queue.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/lsu_stbuf_queue.sv
`timescale 1ns/1ps
// lsu_stbuf_queue
// Committed-store buffer in front of the DCCM/PIC port arbiter. Retired stores
// are queued in order, the oldest is presented as a drain request and popped on
// grant, and loads in DC2 get youngest-wins byte forwarding registered into DC3.
//
// Ports
//   clk, rst                    clock, async active-high reset
//   st_wr_en/addr/data/byteen   store enqueue (addr[1:0] ignored)
//   st_in_pic                   store targets PIC space
//   lsu_stbuf_commit_any        arbiter grant, head drains this cycle
//   lsu_freeze_dc3              hold the DC3 forwarding registers
//   ld_addr_lo_dc2/hi_dc2       load lo/hi bank word addresses
//   stbuf_reqvld_any/addr/data/addr_in_pic_any   head-of-queue drain request
//   stbuf_fwddata_*_dc3, stbuf_fwdbyteen_*_dc3  forwarded bytes and valids
//   stbuf_full, stbuf_empty     occupancy flags
//   stbuf_ovf_err               1-cycle pulse when an enqueue was dropped
module lsu_stbuf_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_wr_en,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [3:0]        st_byteen,
    input  logic              st_in_pic,
    input  logic              lsu_stbuf_commit_any,
    input  logic              lsu_freeze_dc3,
    input  logic [ADDR_W-1:0] ld_addr_lo_dc2,
    input  logic [ADDR_W-1:0] ld_addr_hi_dc2,
    output logic              stbuf_reqvld_any,
    output logic [ADDR_W-1:0] stbuf_addr_any,
    output logic [31:0]       stbuf_data_any,
    output logic              stbuf_addr_in_pic_any,
    output logic [31:0]       stbuf_fwddata_lo_dc3,
    output logic [31:0]       stbuf_fwddata_hi_dc3,
    output logic [3:0]        stbuf_fwdbyteen_lo_dc3,
    output logic [3:0]        stbuf_fwdbyteen_hi_dc3,
    output logic              stbuf_full,
    output logic              stbuf_empty,
    output logic              stbuf_ovf_err
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]        wr_ptr, rd_ptr;
    logic [PW-1:0]      wr_idx, rd_idx;
    logic [DEPTH-1:0]   ent_vld, ent_pic;
    logic [ADDR_W-3:0]  ent_addr [DEPTH];
    logic [31:0]        ent_data [DEPTH];
    logic [3:0]         ent_be   [DEPTH];

    logic               pop, push, drop;
    logic [PW-1:0]      fwd_idx;
    logic [31:0]        fwd_data_lo, fwd_data_hi;
    logic [3:0]         fwd_be_lo, fwd_be_hi;

    assign wr_idx = wr_ptr[PW-1:0];
    assign rd_idx = rd_ptr[PW-1:0];

    // Extra pointer MSB tells a full ring from an empty one.
    assign stbuf_empty = (wr_ptr == rd_ptr);
    assign stbuf_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);

    assign stbuf_reqvld_any      = ~stbuf_empty;
    assign stbuf_addr_any        = {ent_addr[rd_idx], 2'b00};
    assign stbuf_data_any        = ent_data[rd_idx];
    assign stbuf_addr_in_pic_any = ent_pic[rd_idx];

    assign pop  = lsu_stbuf_commit_any & ~stbuf_empty;
    // A pop in the same cycle frees the slot, so a push at full is still legal.
    assign push = st_wr_en & (~stbuf_full | pop);
    assign drop = st_wr_en & stbuf_full & ~pop;

    // Walk entries oldest to youngest so later matches overwrite earlier ones.
    always_comb begin
        fwd_idx     = '0;
        fwd_data_lo = '0;
        fwd_data_hi = '0;
        fwd_be_lo   = '0;
        fwd_be_hi   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_idx + PW'(i);
            if (ent_vld[fwd_idx] && (ent_addr[fwd_idx] == ld_addr_lo_dc2[ADDR_W-1:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (ent_be[fwd_idx][b]) begin
                        fwd_be_lo[b]         = 1'b1;
                        fwd_data_lo[8*b +: 8] = ent_data[fwd_idx][8*b +: 8];
                    end
                end
            end
            if (ent_vld[fwd_idx] && (ent_addr[fwd_idx] == ld_addr_hi_dc2[ADDR_W-1:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (ent_be[fwd_idx][b]) begin
                        fwd_be_hi[b]         = 1'b1;
                        fwd_data_hi[8*b +: 8] = ent_data[fwd_idx][8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr                 <= '0;
            rd_ptr                 <= '0;
            ent_vld                <= '0;
            ent_pic                <= '0;
            stbuf_ovf_err          <= 1'b0;
            stbuf_fwddata_lo_dc3   <= '0;
            stbuf_fwddata_hi_dc3   <= '0;
            stbuf_fwdbyteen_lo_dc3 <= '0;
            stbuf_fwdbyteen_hi_dc3 <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
                ent_be[i]   <= '0;
            end
        end else begin
            stbuf_ovf_err <= drop;
            // Pop before push: at full both target the same slot and the push must win.
            if (pop) begin
                ent_vld[rd_idx] <= 1'b0;
                rd_ptr          <= rd_ptr + {{PW{1'b0}}, 1'b1};
            end
            if (push) begin
                ent_vld[wr_idx]  <= 1'b1;
                ent_addr[wr_idx] <= st_addr[ADDR_W-1:2];
                ent_data[wr_idx] <= st_data;
                ent_be[wr_idx]   <= st_byteen;
                ent_pic[wr_idx]  <= st_in_pic;
                wr_ptr           <= wr_ptr + {{PW{1'b0}}, 1'b1};
            end
            if (!lsu_freeze_dc3) begin
                stbuf_fwddata_lo_dc3   <= fwd_data_lo;
                stbuf_fwddata_hi_dc3   <= fwd_data_hi;
                stbuf_fwdbyteen_lo_dc3 <= fwd_be_lo;
                stbuf_fwdbyteen_hi_dc3 <= fwd_be_hi;
            end
        end
    end

endmodule
